// File: rtl/t5_pkg.sv
// Shared definitions for the t5 execute unit: funct3 encodings and the
// multiply/divide sequencing states.
package t5_pkg;

  localparam logic [2:0] F3Add  = 3'd0;
  localparam logic [2:0] F3Sll  = 3'd1;
  localparam logic [2:0] F3Slt  = 3'd2;
  localparam logic [2:0] F3Sltu = 3'd3;
  localparam logic [2:0] F3Xor  = 3'd4;
  localparam logic [2:0] F3Srl  = 3'd5;
  localparam logic [2:0] F3Or   = 3'd6;
  localparam logic [2:0] F3And  = 3'd7;

  localparam logic [2:0] F3Mul    = 3'd0;
  localparam logic [2:0] F3Mulh   = 3'd1;
  localparam logic [2:0] F3Mulhsu = 3'd2;
  localparam logic [2:0] F3Mulhu  = 3'd3;
  localparam logic [2:0] F3Div    = 3'd4;
  localparam logic [2:0] F3Divu   = 3'd5;
  localparam logic [2:0] F3Rem    = 3'd6;
  localparam logic [2:0] F3Remu   = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } xalu_state_e;

endpackage

// File: rtl/t5_xalu_md.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide on
// operand magnitudes, one bit per enabled cycle, sign fix-up applied on the result.
module t5_xalu_md
  import t5_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            sena,
  input  logic            load,
  input  logic [2:0]      fn3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  xalu_state_e     state,
  output logic            skip,
  output logic            last,
  output logic [XLEN-1:0] res
);

  localparam int unsigned CntW = $clog2(XLEN);

  // hi: multiply upper partial / divide remainder; lo: multiplier / quotient
  logic [XLEN:0]   hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [2:0]      fn_q, fn_d;
  logic            neg_q, neg_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            is_div, sgn1, sgn2, neg1, neg2, div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2;

  always_comb begin
    is_div   = fn3[2];
    sgn1     = is_div ? ~fn3[0] : (fn3 == F3Mulh || fn3 == F3Mulhsu);
    sgn2     = is_div ? ~fn3[0] : (fn3 == F3Mulh);
    neg1     = sgn1 & op1[XLEN-1];
    neg2     = sgn2 & op2[XLEN-1];
    mag1     = neg1 ? -op1 : op1;
    mag2     = neg2 ? -op2 : op2;
    div_zero = (op2 == '0);
    div_ovf  = sgn1 & (op1 == {1'b1, {(XLEN-1){1'b0}}}) & (&op2);
    skip     = is_div & (div_zero | div_ovf);
  end

  logic [XLEN-1:0] mul_add;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rsh;
  logic            ge;
  logic [XLEN-1:0] rdiff;

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    fn_d    = fn_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    mul_add = lo_q[0] ? opnd_q : '0;
    mul_sum = hi_q + {1'b0, mul_add};
    rsh     = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    ge      = (rsh >= {1'b0, opnd_q});
    rdiff   = rsh[XLEN-1:0] - opnd_q;
    if (load) begin
      fn_d  = fn3;
      cnt_d = '0;
      if (is_div && div_zero) begin
        lo_d  = '1;
        hi_d  = {1'b0, op1};
        neg_d = 1'b0;
      end else if (is_div && div_ovf) begin
        lo_d  = op1;
        hi_d  = '0;
        neg_d = 1'b0;
      end else if (is_div) begin
        hi_d   = '0;
        lo_d   = mag1;
        opnd_d = mag2;
        // remainder follows the dividend, quotient follows the sign product
        neg_d  = fn3[1] ? neg1 : (neg1 ^ neg2);
      end else begin
        hi_d   = '0;
        lo_d   = mag2;
        opnd_d = mag1;
        neg_d  = neg1 ^ neg2;
      end
    end else if (sena && state == StMul) begin
      hi_d  = {1'b0, mul_sum[XLEN:1]};
      lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
      cnt_d = cnt_q + CntW'(1);
    end else if (sena && state == StDiv) begin
      hi_d  = {1'b0, (ge ? rdiff : rsh[XLEN-1:0])};
      lo_d  = {lo_q[XLEN-2:0], ge};
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      fn_q   <= '0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      fn_q   <= fn_d;
      neg_q  <= neg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last = (cnt_q == CntW'(XLEN - 1));

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   mul_res, div_sel, div_res;

  always_comb begin
    prod    = {hi_q[XLEN-1:0], lo_q};
    prod_s  = neg_q ? -prod : prod;
    mul_res = (fn_q == F3Mul) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    div_sel = fn_q[1] ? hi_q[XLEN-1:0] : lo_q;
    div_res = neg_q ? -div_sel : div_sel;
    res     = fn_q[2] ? div_res : mul_res;
  end

endmodule

// File: rtl/t5_xalu.sv
// Integer execute unit: single-cycle ALU plus sequencing of the iterative M-extension
// datapath; one registered result pulse per accepted operation.
module t5_xalu
  import t5_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned MULDIV = 1
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            sena,
  input  logic            dvld,
  output logic            drdy,
  input  logic [XLEN-1:0] dop1,
  input  logic [XLEN-1:0] dop2,
  input  logic [2:0]      dfn3,
  input  logic            dalt,
  input  logic            dmul,
  input  logic            dimm,
  output logic            xvld,
  output logic [XLEN-1:0] xres,
  output logic            xbsy
);

  localparam int unsigned ShW = $clog2(XLEN);

  xalu_state_e     state_q, state_d;
  logic [XLEN-1:0] xres_q, xres_d;
  logic            xvld_q, xvld_d;

  logic            accept, m_op, m_load;
  logic            md_skip, md_last;
  logic [XLEN-1:0] md_res;

  assign drdy   = (state_q == StIdle);
  assign xbsy   = ~drdy;
  assign accept = sena & dvld & drdy;
  assign m_op   = (MULDIV != 0) & dmul & ~dimm;
  assign m_load = accept & m_op;

  logic [ShW-1:0]  shamt;
  logic            slt_lt, sltu_lt;
  logic [XLEN-1:0] sra_res, alu_res;

  always_comb begin
    shamt   = dop2[ShW-1:0];
    slt_lt  = 1'(({dop1[XLEN-1], dop1} - {dop2[XLEN-1], dop2}) >> XLEN);
    sltu_lt = 1'(({1'b0, dop1} - {1'b0, dop2}) >> XLEN);
    sra_res = $signed(dop1) >>> shamt;
    alu_res = '0;
    if (dmul && !dimm) begin
      // M ops reach here only when the M path is disabled
      alu_res = dop1 + dop2;
    end else begin
      unique case (dfn3)
        F3Add:   alu_res = (dalt && !dimm) ? dop1 - dop2 : dop1 + dop2;
        F3Sll:   alu_res = dop1 << shamt;
        F3Slt:   alu_res = {{(XLEN-1){1'b0}}, slt_lt};
        F3Sltu:  alu_res = {{(XLEN-1){1'b0}}, sltu_lt};
        F3Xor:   alu_res = dop1 ^ dop2;
        F3Srl:   alu_res = dalt ? sra_res : dop1 >> shamt;
        F3Or:    alu_res = dop1 | dop2;
        F3And:   alu_res = dop1 & dop2;
        default: alu_res = '0;
      endcase
    end
  end

  t5_xalu_md #(
    .XLEN (XLEN)
  ) u_md (
    .sclk  (sclk),
    .srst  (srst),
    .sena  (sena),
    .load  (m_load),
    .fn3   (dfn3),
    .op1   (dop1),
    .op2   (dop2),
    .state (state_q),
    .skip  (md_skip),
    .last  (md_last),
    .res   (md_res)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (m_load) begin
          if (!dfn3[2])     state_d = StMul;
          else if (md_skip) state_d = StDone;
          else              state_d = StDiv;
        end
      end
      StMul, StDiv: if (sena && md_last) state_d = StDone;
      StDone:       if (sena) state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  // xvld is a pulse, so it drops even while sena holds everything else
  always_comb begin
    xres_d = xres_q;
    xvld_d = 1'b0;
    if (accept && !m_op) begin
      xres_d = alu_res;
      xvld_d = 1'b1;
    end else if (sena && state_q == StDone) begin
      xres_d = md_res;
      xvld_d = 1'b1;
    end
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      state_q <= StIdle;
      xres_q  <= '0;
      xvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xres_q  <= xres_d;
      xvld_q  <= xvld_d;
    end
  end

  assign xres = xres_q;
  assign xvld = xvld_q;

endmodule

// File: tb/tb_t5_xalu.sv
// Directed bench for t5_xalu at XLEN=32 and XLEN=64, checked against an arithmetic
// reference model through a per-cycle scoreboard.
module tb_t5_xalu;

  logic        sclk = 1'b0;
  logic        srst, sena;
  logic        dvld32, dvld64;
  logic [63:0] dop1, dop2;
  logic [2:0]  dfn3;
  logic        dalt, dmul, dimm;

  logic        drdy32, xvld32, xbsy32;
  logic [31:0] xres32;
  logic        drdy64, xvld64, xbsy64;
  logic [63:0] xres64;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] res;
    int          cyc;
    bit          multi;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  always #5 sclk = ~sclk;

  t5_xalu #(.XLEN(32), .MULDIV(1)) u_dut32 (
    .sclk (sclk), .srst (srst), .sena (sena), .dvld (dvld32), .drdy (drdy32),
    .dop1 (dop1[31:0]), .dop2 (dop2[31:0]), .dfn3 (dfn3), .dalt (dalt), .dmul (dmul),
    .dimm (dimm), .xvld (xvld32), .xres (xres32), .xbsy (xbsy32)
  );

  t5_xalu #(.XLEN(64), .MULDIV(1)) u_dut64 (
    .sclk (sclk), .srst (srst), .sena (sena), .dvld (dvld64), .drdy (drdy64),
    .dop1 (dop1), .dop2 (dop2), .dfn3 (dfn3), .dalt (dalt), .dmul (dmul),
    .dimm (dimm), .xvld (xvld64), .xres (xres64), .xbsy (xbsy64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input int xl, input logic [2:0] fn, input logic alt,
                                        input logic mul, input logic imm,
                                        input logic [63:0] ai, input logic [63:0] bi);
    logic [63:0]        mask, a, b, r;
    longint             sa, sb;
    int                 sh;
    bit                 sg1, sg2;
    logic signed [127:0] pa, pb, pp, pq, pr, ps;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a    = ai & mask;
    b    = bi & mask;
    if (xl == 64) begin
      sa = longint'(a);
      sb = longint'(b);
    end else begin
      sa = longint'($signed(a[31:0]));
      sb = longint'($signed(b[31:0]));
    end
    sh = int'(b[5:0]) & (xl - 1);
    r  = '0;
    if (mul && !imm) begin
      sg1 = (fn == 3'd1 || fn == 3'd2 || fn == 3'd4 || fn == 3'd6);
      sg2 = (fn == 3'd1 || fn == 3'd4 || fn == 3'd6);
      if (sg1) pa = sa; else pa = {64'd0, a};
      if (sg2) pb = sb; else pb = {64'd0, b};
      if (!fn[2]) begin
        pp = pa * pb;
        ps = pp >> xl;
        r  = (fn == 3'd0) ? pp[63:0] : ps[63:0];
      end else begin
        if (b == 0) begin
          pq = -1;
          pr = pa;
        end else begin
          pq = pa / pb;
          pr = pa % pb;
        end
        r = fn[1] ? pr[63:0] : pq[63:0];
      end
    end else begin
      case (fn)
        3'd0: r = (alt && !imm) ? a - b : a + b;
        3'd1: r = a << sh;
        3'd2: r = (sa < sb) ? 64'd1 : 64'd0;
        3'd3: r = (a < b) ? 64'd1 : 64'd0;
        3'd4: r = a ^ b;
        3'd5: r = alt ? 64'(sa >>> sh) : a >> sh;
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
    return r & mask;
  endfunction

  function automatic int model_lat(input int xl, input logic [2:0] fn, input logic mul,
                                   input logic imm, input logic [63:0] ai,
                                   input logic [63:0] bi);
    logic [63:0] mask, a, b, mn;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    mn   = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    a    = ai & mask;
    b    = bi & mask;
    if (!(mul && !imm)) return 1;
    if (!fn[2]) return xl + 2;
    if (b == 0) return 2;
    if (!fn[0] && a == mn && b == mask) return 2;
    return xl + 2;
  endfunction

  function automatic int pend(input int d);
    return (d == 0) ? q32.size() : q64.size();
  endfunction

  task automatic check_cycle(input int d, input logic v, input logic [63:0] r,
                             input logic rdy, input logic bsy);
    exp_t h;
    bit   have;
    have = (pend(d) > 0);
    if (have) h = (d == 0) ? q32[0] : q64[0];
    chk($sformatf("xbsy_vs_drdy%0d", d), {63'd0, bsy}, {63'd0, ~rdy});
    if (have && h.multi && cyc < h.cyc) chk($sformatf("drdy_low_busy%0d", d), {63'd0, rdy}, 64'd0);
    if (v) begin
      if (!have) begin
        chk($sformatf("xvld_unexpected%0d", d), {63'd0, v}, 64'd0);
      end else begin
        chk($sformatf("xres%0d", d), r, h.res);
        chk($sformatf("xvld_cycle%0d", d), 64'(cyc), 64'(h.cyc));
        if (d == 0) void'(q32.pop_front()); else void'(q64.pop_front());
      end
    end else if (have && cyc >= h.cyc) begin
      chk($sformatf("xvld_missing%0d", d), {63'd0, v}, 64'd1);
      if (d == 0) void'(q32.pop_front()); else void'(q64.pop_front());
    end
  endtask

  initial begin
    forever begin
      @(posedge sclk);
      cyc++;
      #1;
      check_cycle(0, xvld32, {32'd0, xres32}, drdy32, xbsy32);
      check_cycle(1, xvld64, xres64, drdy64, xbsy64);
    end
  end

  task automatic issue(input int d, input logic [2:0] fn, input logic alt, input logic mul,
                       input logic imm, input logic [63:0] a, input logic [63:0] b,
                       input int stall_at, input int stall_len, input bit wait_done,
                       input bit has_lit, input logic [63:0] lit);
    exp_t x;
    int   xl, lat, n;
    xl = (d == 0) ? 32 : 64;
    n  = 0;
    while (!((d == 0) ? drdy32 : drdy64) && n < 200) begin
      @(negedge sclk);
      n++;
    end
    if (n >= 200) chk("drdy_timeout", 64'd0, 64'd1);
    dop1   = a;
    dop2   = b;
    dfn3   = fn;
    dalt   = alt;
    dmul   = mul;
    dimm   = imm;
    sena   = 1'b1;
    dvld32 = (d == 0);
    dvld64 = (d == 1);
    x.res  = model(xl, fn, alt, mul, imm, a, b);
    lat    = model_lat(xl, fn, mul, imm, a, b);
    if (has_lit) chk("model_pin", x.res, lit);
    x.cyc   = cyc + 1 + lat - 1 + stall_len;
    x.multi = (lat > 1);
    if (d == 0) q32.push_back(x); else q64.push_back(x);
    @(negedge sclk);
    dvld32 = 1'b0;
    dvld64 = 1'b0;
    if (stall_len > 0) begin
      repeat (stall_at) @(negedge sclk);
      sena = 1'b0;
      repeat (stall_len) @(negedge sclk);
      sena = 1'b1;
    end
    if (wait_done) begin
      n = 0;
      while (pend(d) > 0 && n < 300) begin
        @(negedge sclk);
        n++;
      end
      if (n >= 300) begin
        chk("result_timeout", 64'd0, 64'd1);
        q32.delete();
        q64.delete();
      end
    end
  endtask

  localparam logic [63:0] M32 = 64'hFFFF_FFFF;
  localparam logic [63:0] M64 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    srst = 1'b1; sena = 1'b0; dvld32 = 1'b0; dvld64 = 1'b0;
    dop1 = '0; dop2 = '0; dfn3 = '0; dalt = 1'b0; dmul = 1'b0; dimm = 1'b0;
    repeat (3) @(negedge sclk);
    srst = 1'b0;
    chk("rst_drdy32", {63'd0, drdy32}, 64'd1);
    chk("rst_xvld32", {63'd0, xvld32}, 64'd0);
    chk("rst_xres32", {32'd0, xres32}, 64'd0);
    chk("rst_xbsy32", {63'd0, xbsy32}, 64'd0);
    chk("rst_drdy64", {63'd0, drdy64}, 64'd1);
    chk("rst_xres64", xres64, 64'd0);
    sena = 1'b1;
    @(negedge sclk);

    // XLEN=32 ALU
    issue(0, 3'd0, 1, 0, 0, 64'd5, 64'd7, 0, 0, 1, 1, 64'hFFFF_FFFE);
    issue(0, 3'd0, 0, 0, 0, 64'h7FFF_FFFF, 64'd1, 0, 0, 1, 1, 64'h8000_0000);
    issue(0, 3'd0, 1, 0, 1, 64'd10, 64'd3, 0, 0, 1, 1, 64'd13);
    issue(0, 3'd1, 0, 0, 0, 64'd1, 64'd33, 0, 0, 1, 1, 64'd2);
    issue(0, 3'd2, 0, 0, 0, M32, 64'd1, 0, 0, 1, 1, 64'd1);
    issue(0, 3'd3, 0, 0, 0, M32, 64'd1, 0, 0, 1, 1, 64'd0);
    issue(0, 3'd4, 0, 0, 0, 64'hF0F0_F0F0, 64'h0FF0_0FF0, 0, 0, 1, 1, 64'hFF00_FF00);
    issue(0, 3'd5, 0, 0, 0, 64'h8000_0000, 64'd4, 0, 0, 1, 1, 64'h0800_0000);
    issue(0, 3'd5, 1, 0, 1, 64'h8000_0000, 64'd4, 0, 0, 1, 1, 64'hF800_0000);
    issue(0, 3'd6, 0, 0, 0, 64'h12, 64'h03, 0, 0, 1, 1, 64'h13);
    issue(0, 3'd7, 0, 0, 0, 64'hFF, 64'h0F, 0, 0, 1, 1, 64'h0F);
    issue(0, 3'd0, 0, 1, 1, 64'd2, 64'd3, 0, 0, 1, 1, 64'd5);

    // XLEN=32 multiply
    issue(0, 3'd1, 0, 1, 0, M32, M32, 0, 0, 1, 1, 64'd0);
    issue(0, 3'd0, 0, 1, 0, M32, M32, 0, 0, 1, 1, 64'd1);
    issue(0, 3'd2, 0, 1, 0, M32, 64'd2, 0, 0, 1, 1, 64'hFFFF_FFFF);
    issue(0, 3'd3, 0, 1, 0, M32, M32, 0, 0, 1, 1, 64'hFFFF_FFFE);
    issue(0, 3'd0, 0, 1, 0, 64'd12345, 64'hFFFF_FD5A, 0, 0, 1, 0, 64'd0);

    // XLEN=32 divide, including the direct-to-done cases
    issue(0, 3'd4, 0, 1, 0, 64'h8000_0000, M32, 0, 0, 1, 1, 64'h8000_0000);
    issue(0, 3'd6, 0, 1, 0, 64'h8000_0000, M32, 0, 0, 1, 1, 64'd0);
    issue(0, 3'd6, 0, 1, 0, 64'd7, 64'd0, 0, 0, 1, 1, 64'd7);
    issue(0, 3'd5, 0, 1, 0, 64'd5, 64'd0, 0, 0, 1, 1, 64'hFFFF_FFFF);
    issue(0, 3'd6, 0, 1, 0, 64'hFFFF_FFF9, 64'd2, 0, 0, 1, 1, 64'hFFFF_FFFF);
    issue(0, 3'd4, 0, 1, 0, 64'hFFFF_FFF9, 64'd2, 0, 0, 1, 1, 64'hFFFF_FFFD);
    issue(0, 3'd5, 0, 1, 0, 64'd100, 64'd7, 3, 5, 1, 1, 64'd14);
    issue(0, 3'd7, 0, 1, 0, 64'd100, 64'd7, 0, 0, 1, 1, 64'd2);

    // XLEN=64
    issue(1, 3'd5, 1, 0, 0, 64'h8000_0000_0000_0000, 64'd63, 0, 0, 1, 1, M64);
    issue(1, 3'd3, 0, 0, 0, 64'd1, M64, 0, 0, 1, 1, 64'd1);
    issue(1, 3'd1, 0, 1, 0, M64 - 64'd2, 64'd5, 0, 0, 1, 1, M64);
    issue(1, 3'd4, 0, 1, 0, M64 - 64'd99, 64'd7, 0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF2);

    // abort a divide mid-iteration with srst
    issue(0, 3'd4, 0, 1, 0, 64'd1000, 64'd3, 0, 0, 0, 0, 64'd0);
    repeat (9) @(negedge sclk);
    srst = 1'b1;
    q32.delete();
    @(negedge sclk);
    srst = 1'b0;
    chk("abort_drdy", {63'd0, drdy32}, 64'd1);
    chk("abort_xbsy", {63'd0, xbsy32}, 64'd0);
    chk("abort_xres", {32'd0, xres32}, 64'd0);
    @(negedge sclk);
    chk("abort_drdy_after", {63'd0, drdy32}, 64'd1);
    repeat (40) @(negedge sclk);
    issue(0, 3'd0, 0, 0, 0, 64'd1, 64'd1, 0, 0, 1, 1, 64'd2);

    repeat (5) @(negedge sclk);
    chk("queue_drain", 64'(q32.size() + q64.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
